inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, fetch address after reset (bits [1:0] SHALL be zero).
REQ-002 Port: clk  input  1  sole clock; all state SHALL change on its rising edge only.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: imem_req  output  1  one-cycle fetch request pulse to instruction memory.
REQ-005 Port: imem_addr  output  32  word-aligned fetch address, valid when imem_req=1.
REQ-006 Port: imem_rvalid  input  1  response strobe, 1..N cycles after imem_req.
REQ-007 Port: imem_rdata  input  32  instruction word, valid when imem_rvalid=1.
REQ-008 Port: redir_valid  input  1  redirect (taken branch or jump) from execute/decode.
REQ-009 Port: redir_pc  input  32  redirect target, sampled when redir_valid=1.
REQ-010 Port: inst_valid  output  1  instruction available to the decoder.
REQ-011 Port: inst  output  32  buffered instruction word.
REQ-012 Port: inst_pc  output  32  address the buffered instruction was fetched from.
REQ-013 Port: op  output  6  inst[31:26], opcode field for the main decoder.
REQ-014 Port: dec_ready  input  1  decoder accepts the instruction this cycle.

Function
REQ-015 States SHALL be FETCH, WAIT, DROP; at most one request outstanding.
REQ-016 FETCH: if buffer free (inst_valid=0 or dec_ready=1) and redir_valid=0, assert imem_req with imem_addr=pc, latch req_pc=pc, pc<=pc+4, go WAIT; else stay FETCH, imem_req=0.
REQ-017 WAIT: on imem_rvalid=1 and redir_valid=0, load inst<=imem_rdata, inst_pc<=req_pc, inst_valid<=1, go FETCH.
REQ-018 Transfer SHALL occur on a cycle with inst_valid=1 and dec_ready=1; inst_valid clears then unless a new load occurs the same cycle.
REQ-019 While inst_valid=1 and dec_ready=0, inst, inst_pc and op SHALL hold stable.
REQ-020 Redirect priority: redir_valid=1 SHALL override every other event in the same cycle.
REQ-021 Redirect in any state: pc<={redir_pc[31:2],2'b00}, inst_valid<=0, imem_req=0 that cycle.
REQ-022 Redirect in WAIT with imem_rvalid=0: go DROP; with imem_rvalid=1 same cycle: discard data, go FETCH.
REQ-023 DROP: on imem_rvalid=1 discard data, go FETCH; buffer SHALL NOT load.
REQ-024 Redirect in DROP: update pc again, remain DROP.
REQ-025 pc increment SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-026 imem_rvalid in FETCH SHALL be ignored.
REQ-027 Best-case throughput: one instruction per 2 cycles with 1-cycle memory latency and dec_ready=1.
REQ-028 op SHALL be combinational from the inst register.

Reset
REQ-029 On rst=1 at a clock edge: state=FETCH, pc=RESET_PC, inst_valid=0, inst=0, inst_pc=0, imem_req=0.
REQ-030 Reset mid-WAIT SHALL abandon the outstanding request; a late imem_rvalid after reset SHALL be ignored (state FETCH).
REQ-031 imem_req SHALL be 0 during the reset cycle and the first FETCH cycle after reset release SHALL issue RESET_PC.

Structure
REQ-032 Shared package SHALL hold: state enum (FETCH, WAIT, DROP), RESET_PC default, opcode constants (OP_RTYPE 6'b000000, OP_LW 6'b100011, OP_SW 6'b101011, OP_BEQ 6'b000100, OP_ADDI 6'b001000, OP_J 6'b000010).
REQ-033 One sub-module SHALL be used: inst_buf, the single-entry valid/ready output register (load, flush, hold).

Verification
REQ-034 Reset, rst released, 1-cycle memory returning 32'h8C08_0004 -> imem_addr 0, then inst_valid=1, inst=32'h8C08_0004, op=6'b100011, inst_pc=0; next imem_addr=4.
REQ-035 dec_ready=0 for 5 cycles with inst buffered -> no imem_req issued, inst/inst_pc stable; dec_ready=1 -> next request at pc+4 same cycle.
REQ-036 Redirect redir_pc=32'h0000_0040 in WAIT, response 3 cycles later -> response discarded, inst_valid stays 0, next imem_addr=32'h40.
REQ-037 redir_valid and imem_rvalid same cycle in WAIT, redir_pc=32'h0000_0103 -> data discarded, next imem_addr=32'h100.
REQ-038 RESET_PC=32'hFFFF_FFFC, two fetches -> imem_addr FFFF_FFFC then 0000_0000.
REQ-039 rst asserted in WAIT, stale imem_rvalid one cycle after release -> ignored, inst_valid=0, first request at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared fetch FSM states, reset address and opcode constants
package inst_fetch_pkg;
  typedef enum logic [1:0] {FETCH, WAIT, DROP} state_t;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
endpackage

// File: rtl/inst_fetch_buf.sv
// inst_buf: single-entry valid/ready instruction register (load, flush, hold); ports clk, rst, load/flush/ready controls, din/din_pc in, valid/data/pc out
module inst_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic        ready,
  input  logic [31:0] din,
  input  logic [31:0] din_pc,
  output logic        valid,
  output logic [31:0] data,
  output logic [31:0] pc
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
      pc    <= din_pc;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding instruction fetch FSM with redirect; ports clk/rst, imem req/addr/rvalid/rdata, redir valid/pc, inst_valid/inst/inst_pc/op out, dec_ready in
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [5:0]  op,
  input  logic        dec_ready
);
  state_t state, state_n;
  logic [31:0] pc, req_pc;
  logic free, load;
  assign free = !inst_valid || dec_ready;
  assign imem_addr = pc;
  assign op = inst[31:26];
  always_comb begin
    state_n  = state;
    imem_req = 1'b0;
    load     = 1'b0;
    case (state)
      FETCH: if (!redir_valid && free) begin
        imem_req = 1'b1;
        state_n  = WAIT;
      end
      WAIT: if (redir_valid) state_n = imem_rvalid ? FETCH : DROP;
      else if (imem_rvalid) begin
        load    = 1'b1;
        state_n = FETCH;
      end
      // a response landing with a redirect still ends the outstanding request
      DROP: state_n = imem_rvalid ? FETCH : DROP;
      default: state_n = FETCH;
    endcase
    if (rst) begin
      imem_req = 1'b0;
      load     = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FETCH;
      pc     <= RESET_PC & ~32'h3;
      req_pc <= '0;
    end else begin
      state <= state_n;
      if (redir_valid) pc <= redir_pc & ~32'h3;
      else if (imem_req) begin
        req_pc <= pc;
        pc     <= pc + 32'd4;
      end
    end
  end
  inst_buf u_buf (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .flush  (redir_valid),
    .ready  (dec_ready),
    .din    (imem_rdata),
    .din_pc (req_pc),
    .valid  (inst_valid),
    .data   (inst),
    .pc     (inst_pc)
  );
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed self-checking bench for inst_fetch, including a wrap-around instance
module tb_inst_fetch;
  import inst_fetch_pkg::*;
  logic clk = 0;
  logic rst, rvalid, redir, rdy;
  logic [31:0] rdata, rpc;
  logic req, w_req, iv, w_iv;
  logic [31:0] addr, ins, ipc, w_addr, w_ins, w_ipc;
  logic [5:0] op, w_op;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  inst_fetch u_dut (
    .clk(clk), .rst(rst), .imem_req(req), .imem_addr(addr), .imem_rvalid(rvalid),
    .imem_rdata(rdata), .redir_valid(redir), .redir_pc(rpc), .inst_valid(iv),
    .inst(ins), .inst_pc(ipc), .op(op), .dec_ready(rdy)
  );
  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr), .imem_rvalid(rvalid),
    .imem_rdata(rdata), .redir_valid(redir), .redir_pc(rpc), .inst_valid(w_iv),
    .inst(w_ins), .inst_pc(w_ipc), .op(w_op), .dec_ready(rdy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  initial begin
    rst = 1; rvalid = 0; rdata = 0; redir = 0; rpc = 0; rdy = 1;
    cyc();
    cyc();
    #1;
    chk("rst_req", 32'(req), 0);
    chk("rst_iv", 32'(iv), 0);
    chk("rst_inst", ins, 0);
    chk("rst_ipc", ipc, 0);
    cyc();
    rst = 0;
    #1;
    chk("req0", 32'(req), 1);
    chk("addr0", addr, 0);
    chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    cyc();
    rvalid = 1; rdata = 32'h8C08_0004;
    #1;
    chk("wait_req", 32'(req), 0);
    cyc();
    rvalid = 0; rdy = 0;
    #1;
    chk("lw_iv", 32'(iv), 1);
    chk("lw_inst", ins, 32'h8C08_0004);
    chk("lw_op", 32'(op), 32'(OP_LW));
    chk("lw_ipc", ipc, 0);
    chk("addr4", addr, 4);
    chk("wrap_addr1", w_addr, 0);
    chk("stall_req0", 32'(req), 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      #1;
      chk("stall_req", 32'(req), 0);
      chk("stall_inst", ins, 32'h8C08_0004);
      chk("stall_ipc", ipc, 0);
      chk("stall_iv", 32'(iv), 1);
    end
    cyc();
    rdy = 1;
    #1;
    chk("resume_req", 32'(req), 1);
    chk("resume_addr", addr, 4);
    chk("wrap_req1", 32'(w_req), 1);
    cyc();
    redir = 1; rpc = 32'h0000_0040;
    #1;
    chk("redir_req", 32'(req), 0);
    cyc();
    redir = 0;
    #1;
    chk("drop_iv", 32'(iv), 0);
    chk("drop_req", 32'(req), 0);
    cyc();
    #1;
    chk("drop_req2", 32'(req), 0);
    cyc();
    rvalid = 1; rdata = 32'hDEAD_BEEF;
    #1;
    chk("drop_req3", 32'(req), 0);
    cyc();
    rvalid = 0;
    #1;
    chk("drop_discard", 32'(iv), 0);
    chk("redir_req2", 32'(req), 1);
    chk("redir_addr", addr, 32'h40);
    cyc();
    rvalid = 1; rdata = 32'h2008_0005;
    cyc();
    rvalid = 0;
    #1;
    chk("addi_iv", 32'(iv), 1);
    chk("addi_op", 32'(op), 32'(OP_ADDI));
    chk("addi_ipc", ipc, 32'h40);
    chk("tput_req", 32'(req), 1);
    chk("tput_addr", addr, 32'h44);
    cyc();
    redir = 1; rpc = 32'h0000_0103; rvalid = 1; rdata = 32'hFFFF_FFFF;
    #1;
    chk("coll_req", 32'(req), 0);
    cyc();
    redir = 0; rvalid = 0;
    #1;
    chk("coll_iv", 32'(iv), 0);
    chk("coll_req2", 32'(req), 1);
    chk("coll_addr", addr, 32'h100);
    cyc();
    rst = 1;
    cyc();
    #1;
    chk("mrst_req", 32'(req), 0);
    chk("mrst_iv", 32'(iv), 0);
    cyc();
    rst = 0; rvalid = 1; rdata = 32'h1234_5678;
    #1;
    chk("mrst_req2", 32'(req), 1);
    chk("mrst_addr", addr, 0);
    cyc();
    rvalid = 0;
    #1;
    chk("stale_iv", 32'(iv), 0);
    chk("stale_req", 32'(req), 0);
    cyc();
    rvalid = 1; rdata = 32'h1000_FFFF;
    cyc();
    rvalid = 0;
    #1;
    chk("beq_iv", 32'(iv), 1);
    chk("beq_op", 32'(op), 32'(OP_BEQ));
    chk("beq_ipc", ipc, 0);
    chk("beq_inst", ins, 32'h1000_FFFF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
